// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state type and helpers for lsu_ctrl
package lsu_pkg;

  localparam int unsigned MEM_BYTES_DEF  = 16384;
  localparam int unsigned ADDR_LIMIT_DEF = MEM_BYTES_DEF - 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_MERGE, S_WRITE, S_RESP} state_t;

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    if (store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Narrow stores keep the untouched upper bytes of the current memory word.
  function automatic logic [31:0] merge_store(input logic [2:0] f3, input logic [31:0] rd,
                                              input logic [31:0] wd);
    case (f3)
      F3_B:    return {rd[31:8], wd[7:0]};
      F3_H:    return {rd[31:16], wd[15:0]};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - request, response and data-memory bundle for lsu_ctrl
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_write;
  logic [31:0] dmem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, rsp_ready, dmem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, dmem_addr, dmem_wdata, dmem_write
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, rsp_ready, dmem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, dmem_addr, dmem_wdata, dmem_write
  );
endinterface

// File: rtl/lsu_extend.sv
// rtl/lsu_extend.sv - load size selection with sign/zero extension
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_word;
    case (i_funct3)
      F3_B:    o_data = {{24{i_word[7]}}, i_word[7:0]};
      F3_H:    o_data = {{16{i_word[15]}}, i_word[15:0]};
      F3_BU:   o_data = {24'd0, i_word[7:0]};
      F3_HU:   o_data = {16'd0, i_word[15:0]};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - single-outstanding load/store controller with read-modify-write for SB/SH
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = MEM_BYTES_DEF,
  parameter int unsigned ADDR_LIMIT = MEM_BYTES - 4
) (
  input  logic        clk,
  input  logic        rst,
  lsu_ctrl_if.slave   bus
);

  state_t      r_state;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  logic        r_rd_wait;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic        r_rsp_fault;
  logic [31:0] r_rsp_rdata;
  logic        r_dmem_write;
  logic [31:0] r_dmem_addr;
  logic [31:0] r_dmem_wdata;

  logic        w_accept;
  logic        w_fault;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign w_accept = bus.req_valid & r_req_ready;
  assign w_fault  = !f3_legal(bus.req_store, bus.req_funct3) || (bus.req_addr > ADDR_LIMIT);
  assign w_merged = merge_store(r_funct3, bus.dmem_rdata, r_wdata);

  lsu_extend u_extend (
    .i_funct3 (r_funct3),
    .i_word   (bus.dmem_rdata),
    .o_data   (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_store      <= 1'b0;
      r_funct3     <= 3'd0;
      r_wdata      <= 32'd0;
      r_rd_wait    <= 1'b0;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_fault  <= 1'b0;
      r_rsp_rdata  <= 32'd0;
      r_dmem_write <= 1'b0;
      r_dmem_addr  <= 32'd0;
      r_dmem_wdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_store     <= bus.req_store;
            r_funct3    <= bus.req_funct3;
            r_wdata     <= bus.req_wdata;
            r_req_ready <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_fault <= w_fault;
            r_rd_wait   <= 1'b0;
            if (w_fault) begin
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_dmem_addr <= bus.req_addr;
              if (bus.req_store && bus.req_funct3 == F3_W) begin
                r_dmem_wdata <= bus.req_wdata;
                r_dmem_write <= 1'b1;
                r_state      <= S_WRITE;
              end else begin
                r_state <= S_READ;
              end
            end
          end
        end
        // Loads spend a second cycle here: the memory output is registered.
        S_READ: begin
          if (r_store) begin
            r_state <= S_MERGE;
          end else if (!r_rd_wait) begin
            r_rd_wait <= 1'b1;
          end else begin
            r_rsp_rdata <= w_load_data;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_MERGE: begin
          r_dmem_wdata <= w_merged;
          r_dmem_write <= 1'b1;
          r_state      <= S_WRITE;
        end
        S_WRITE: begin
          r_dmem_write <= 1'b0;
          r_rsp_valid  <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_fault  = r_rsp_fault;
  assign bus.rsp_rdata  = r_rsp_rdata;
  assign bus.dmem_addr  = r_dmem_addr;
  assign bus.dmem_wdata = r_dmem_wdata;
  // Suppress the write strobe on the edge a reset lands on.
  assign bus.dmem_write = r_dmem_write & ~rst;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl against a byte-array reference model
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int unsigned NBYTES = MEM_BYTES_DEF;
  localparam int unsigned LIMIT  = ADDR_LIMIT_DEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_ctrl_if bus ();

  lsu_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  mem     [0:NBYTES-1];
  logic [7:0]  ref_mem [0:NBYTES-1];
  logic        init_go;
  logic        bd_we;
  logic [31:0] bd_addr;
  logic [7:0]  bd_data;
  int          wr_cnt;
  logic [31:0] last_wdata;
  logic [31:0] last_waddr;
  int          n_assert;
  int          n_fail;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 131) ^ (i >> 3));
  endfunction

  always @(posedge clk) begin
    if (init_go) begin
      for (int i = 0; i < NBYTES; i++) mem[i] <= pat(i);
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (bus.dmem_write === 1'b1 && bus.dmem_addr <= LIMIT) begin
      for (int i = 0; i < 4; i++) mem[bus.dmem_addr + i] <= bus.dmem_wdata[8*i +: 8];
    end
    if (bus.dmem_addr <= LIMIT)
      bus.dmem_rdata <= {mem[bus.dmem_addr + 3], mem[bus.dmem_addr + 2],
                         mem[bus.dmem_addr + 1], mem[bus.dmem_addr]};
    else
      bus.dmem_rdata <= 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (bus.dmem_write === 1'b1) begin
      wr_cnt     <= wr_cnt + 1;
      last_wdata <= bus.dmem_wdata;
      last_waddr <= bus.dmem_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
  endfunction

  // Reference: applies one request to ref_mem and yields the response it must produce.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                       output logic [31:0] wword);
    logic [31:0] w;
    int          nb;
    bit          legal;
    rd = 32'd0;
    wword = 32'd0;
    if (st) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    flt = !legal || (a > LIMIT);
    if (flt) return;
    if (st) begin
      nb = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      for (int i = 0; i < nb; i++) ref_mem[a + i] = wd[8*i +: 8];
      wword = ref_word(a);
    end else begin
      w = ref_word(a);
      case (f3)
        3'd0:    rd = (w[7:0] >= 8'd128) ? 32'(w[7:0]) - 32'd256 : 32'(w[7:0]);
        3'd1:    rd = (w[15:0] >= 16'd32768) ? 32'(w[15:0]) - 32'd65536 : 32'(w[15:0]);
        3'd4:    rd = w % 32'd256;
        3'd5:    rd = w % 32'd65536;
        default: rd = w;
      endcase
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic poke_word(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) poke(a + i, d[8*i +: 8]);
  endtask

  task automatic req(input string tag, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input bit hold,
                     output logic [31:0] got);
    logic [31:0] exp_rd, exp_ww, s_rd;
    logic        exp_f, s_f;
    int          lat, w0;
    model(st, f3, a, wd, exp_rd, exp_f, exp_ww);
    check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    w0 = wr_cnt;
    bus.rsp_ready = !hold;
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, ".rsp_fault"}, 32'(bus.rsp_fault), 32'(exp_f));
    check({tag, ".rsp_rdata"}, bus.rsp_rdata, exp_rd);
    if (!st && !exp_f) check({tag, ".latency"}, 32'(lat), 32'd3);
    if (st && !exp_f) begin
      check({tag, ".writes"}, 32'(wr_cnt - w0), 32'd1);
      check({tag, ".wdata"}, last_wdata, exp_ww);
      check({tag, ".waddr"}, last_waddr, a);
    end else begin
      check({tag, ".writes"}, 32'(wr_cnt - w0), 32'd0);
    end
    got = bus.rsp_rdata;
    if (hold) begin
      s_rd = bus.rsp_rdata; s_f = bus.rsp_fault;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        check({tag, ".hold_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, ".hold_rdata"}, bus.rsp_rdata, s_rd);
        check({tag, ".hold_fault"}, 32'(bus.rsp_fault), 32'(s_f));
        check({tag, ".hold_ready"}, 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, ".idle_valid"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] got, w0;
    logic [7:0]  b30, b35;
    int          bad;
    n_assert = 0; n_fail = 0;
    wr_cnt = 0; last_wdata = 0; last_waddr = 0;
    bd_we = 1'b0; bd_addr = 0; bd_data = 0;
    init_go = 1'b1;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.rsp_ready = 1'b1;
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = pat(i);
    @(posedge clk); #1;
    init_go = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.req_ready", 32'(bus.req_ready), 32'd1);
    check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst.rsp_fault", 32'(bus.rsp_fault), 32'd0);
    check("rst.rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst.dmem_write", 32'(bus.dmem_write), 32'd0);
    check("rst.dmem_addr", bus.dmem_addr, 32'd0);
    check("rst.dmem_wdata", bus.dmem_wdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    poke_word(32'h10, 32'h807F_01FF);
    req("lb", 1'b0, 3'b000, 32'h10, 0, 0, got);   check("lb.const", got, 32'hFFFF_FFFF);
    req("lbu", 1'b0, 3'b100, 32'h10, 0, 0, got);  check("lbu.const", got, 32'h0000_00FF);
    req("lh", 1'b0, 3'b001, 32'h10, 0, 0, got);   check("lh.const", got, 32'h0000_01FF);
    req("lw", 1'b0, 3'b010, 32'h10, 0, 0, got);   check("lw.const", got, 32'h807F_01FF);
    req("lhu", 1'b0, 3'b101, 32'h12, 0, 0, got);  check("lhu.const", got, 32'h0000_807F);

    poke_word(32'h20, 32'h1122_3344);
    req("sb", 1'b1, 3'b000, 32'h20, 32'hAABB_CCDD, 0, got);
    check("sb.wconst", last_wdata, 32'h1122_33DD);
    req("sb_lw", 1'b0, 3'b010, 32'h20, 0, 0, got); check("sb_lw.const", got, 32'h1122_33DD);

    poke_word(32'h31, 32'h5566_7788);
    b30 = ref_mem[32'h30]; b35 = ref_mem[32'h35];
    req("sh", 1'b1, 3'b001, 32'h31, 32'h0000_BEEF, 0, got);
    req("sh_lw", 1'b0, 3'b010, 32'h31, 0, 0, got); check("sh_lw.const", got, 32'h5566_BEEF);
    check("sh.byte30", 32'(mem[32'h30]), 32'(b30));
    check("sh.byte35", 32'(mem[32'h35]), 32'(b35));

    req("sw_oob", 1'b1, 3'b010, 32'd16381, 32'h1234_5678, 0, got);
    req("ld_f3_011", 1'b0, 3'b011, 32'd0, 0, 0, got);
    req("st_f3_100", 1'b1, 3'b100, 32'h40, 32'hFFFF_FFFF, 0, got);
    req("lw_limit", 1'b0, 3'b010, 32'd16380, 0, 0, got);
    req("sw_limit", 1'b1, 3'b010, 32'd16380, 32'hCAFE_F00D, 0, got);
    req("lw_wrap", 1'b0, 3'b010, 32'hFFFF_FFFD, 0, 0, got);
    req("lw_hold", 1'b0, 3'b010, 32'h20, 0, 1, got);
    req("flt_hold", 1'b0, 3'b111, 32'h20, 0, 1, got);

    poke_word(32'h50, 32'h0102_0304);
    w0 = wr_cnt;
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h50; bus.req_wdata = 32'h0000_00EE;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.writes", 32'(wr_cnt) - w0, 32'd0);
    check("abort.req_ready", 32'(bus.req_ready), 32'd1);
    check("abort.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("abort.mem", {mem[32'h53], mem[32'h52], mem[32'h51], mem[32'h50]}, 32'h0102_0304);
    req("abort_lw", 1'b0, 3'b010, 32'h50, 0, 0, got);

    for (int n = 0; n < 60; n++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(16374, 16390))
                                       : 32'($urandom_range(0, 96));
      req("rnd", st, f3, a, $urandom, ($urandom_range(0, 9) == 0), got);
    end

    bad = 0;
    for (int i = 0; i < NBYTES; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("final.mem_diffs", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
